// File: rtl/uart_tx_frame_arb.sv
// uart_tx_frame_arb: round-robin arbiter that frames one requester's 64-bit
// payload into an 11-byte UART frame and streams it byte by byte.
//   I_clk_10M    : system clock, rising edge
//   I_rst        : synchronous active-high reset
//   I_GA         : geographic address placed in byte1 of every frame
//   I_req        : per-requester level request, held until granted
//   I_req_data   : packed payloads, requester k at [64k+63:64k]
//   O_grant      : one-hot pulse when the winner's payload is latched
//   O_tx_data    : byte to the UART transmitter
//   O_tx_ena     : byte valid, held until I_tx_ready
//   I_tx_ready   : transmitter accepts a byte this cycle
//   O_busy       : high while not idle
//   O_frame_done : pulse after the checksum byte is accepted
module uart_tx_frame_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter logic [7:0]  HEADER     = 8'hAA,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                   I_clk_10M,
    input  logic                   I_rst,
    input  logic [4:0]             I_GA,
    input  logic [NUM_REQ-1:0]     I_req,
    input  logic [64*NUM_REQ-1:0]  I_req_data,
    output logic [NUM_REQ-1:0]     O_grant,
    output logic [7:0]             O_tx_data,
    output logic                   O_tx_ena,
    input  logic                   I_tx_ready,
    output logic                   O_busy,
    output logic                   O_frame_done
);

    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]  LAST_BYTE = 4'd10;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [2:0]         sel_q, sel_d;
    logic [4:0]         ga_q, ga_d;
    logic [63:0]        payload_q, payload_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [7:0]         tx_data_d;
    logic               tx_ena_d;
    logic               busy_d;
    logic               done_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [63:0]        win_data;

    // Byte at position idx of the frame being sent
    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [2:0]  sel,
                                              input logic [4:0]  ga,
                                              input logic [63:0] pl,
                                              input logic [7:0]  cs);
        case (idx)
            4'd0:    frame_byte = HEADER;
            4'd1:    frame_byte = {sel, ga};
            4'd2:    frame_byte = pl[63:56];
            4'd3:    frame_byte = pl[55:48];
            4'd4:    frame_byte = pl[47:40];
            4'd5:    frame_byte = pl[39:32];
            4'd6:    frame_byte = pl[31:24];
            4'd7:    frame_byte = pl[23:16];
            4'd8:    frame_byte = pl[15:8];
            4'd9:    frame_byte = pl[7:0];
            default: frame_byte = cs;
        endcase
    endfunction

    // Round-robin pick: first active request at or after last_granted+1
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && I_req[k] &&
                    (k == (int'(last_q) + 1 + i) % NUM_REQ)) begin
                    found = 1'b1;
                    win   = IDX_W'(k);
                end
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IDX_W'(k)) win_data = I_req_data[64*k +: 64];
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        ga_d      = ga_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        gap_d     = gap_q;
        grant_d   = '0;
        tx_ena_d  = 1'b0;
        tx_data_d = 8'h00;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = SEND;
                    last_d    = win;
                    sel_d     = 3'(win);
                    ga_d      = I_GA;
                    payload_d = win_data;
                    idx_d     = 4'd0;
                    csum_d    = 8'h00;
                    grant_d   = NUM_REQ'(1) << win;
                    tx_ena_d  = 1'b1;
                    tx_data_d = HEADER;
                end
            end
            SEND: begin
                tx_ena_d  = 1'b1;
                tx_data_d = O_tx_data;
                if (O_tx_ena && I_tx_ready) begin
                    // Checksum covers bytes 1..9 as they are accepted
                    if (idx_q >= 4'd1 && idx_q <= 4'd9) csum_d = csum_q + O_tx_data;
                    if (idx_q == LAST_BYTE) begin
                        tx_ena_d  = 1'b0;
                        tx_data_d = 8'h00;
                        done_d    = 1'b1;
                        gap_d     = 8'(GAP_CYCLES);
                        state_d   = GAP;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = frame_byte(idx_q + 4'd1, sel_q, ga_q, payload_q, csum_d);
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge I_clk_10M) begin
        if (I_rst) begin
            state_q      <= IDLE;
            last_q       <= IDX_W'(NUM_REQ - 1);
            sel_q        <= '0;
            ga_q         <= '0;
            payload_q    <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            gap_q        <= '0;
            O_grant      <= '0;
            O_tx_data    <= '0;
            O_tx_ena     <= 1'b0;
            O_busy       <= 1'b0;
            O_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            ga_q         <= ga_d;
            payload_q    <= payload_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            gap_q        <= gap_d;
            O_grant      <= grant_d;
            O_tx_data    <= tx_data_d;
            O_tx_ena     <= tx_ena_d;
            O_busy       <= busy_d;
            O_frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_frame_arb: directed frames push expected
// bytes/grants into queues, a negedge monitor pops and compares.
module tb_uart_tx_frame_arb;

    localparam int unsigned NUM_REQ = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [4:0]            ga;
    logic [NUM_REQ-1:0]    req;
    logic [64*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    grant;
    logic [7:0]            tx_data;
    logic                  tx_ena;
    logic                  tx_ready;
    logic                  busy;
    logic                  frame_done;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int d0;

    logic [7:0]         exp_bytes[$];
    logic [NUM_REQ-1:0] exp_grants[$];
    int                 gtimes[$];

    uart_tx_frame_arb #(.NUM_REQ(NUM_REQ), .HEADER(8'hAA), .GAP_CYCLES(16)) dut (
        .I_clk_10M   (clk),
        .I_rst       (rst),
        .I_GA        (ga),
        .I_req       (req),
        .I_req_data  (req_data),
        .O_grant     (grant),
        .O_tx_data   (tx_data),
        .O_tx_ena    (tx_ena),
        .I_tx_ready  (tx_ready),
        .O_busy      (busy),
        .O_frame_done(frame_done)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every grant and every accepted byte against the queues
    always @(negedge clk) begin
        if (grant != '0) begin
            gtimes.push_back(cyc);
            if (exp_grants.size() == 0) chk("unexpected_grant", 64'(grant), 64'h0);
            else                        chk("grant", 64'(grant), 64'(exp_grants.pop_front()));
        end
        if (tx_ena && tx_ready) begin
            if (exp_bytes.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
            end else begin
                chk("tx_byte", 64'(tx_data), 64'(exp_bytes.pop_front()));
            end
        end
        if (frame_done) done_cnt++;
    end

    // Push the first n bytes of an 11-byte frame, byte0 in the top bits
    task automatic push_bytes(input logic [87:0] v, input int n);
        logic [87:0] t;
        t = v;
        for (int i = 0; i < n; i++) exp_bytes.push_back(t[(10-i)*8 +: 8]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int i;
        i = 0;
        @(negedge clk);
        while (grant == '0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("grant_seen", 64'(grant != '0), 64'h1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        @(negedge clk);
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("idle_reached", 64'(!busy), 64'h1);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int i;
        i = 0;
        while (!(tx_ena && tx_data == b) && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("byte_reached", 64'(tx_ena && tx_data == b), 64'h1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        ga       = '0;
        req      = '0;
        req_data = '0;
        tx_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_tx_ena", 64'(tx_ena), 64'h0);
        chk("rst_tx_data", 64'(tx_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(frame_done), 64'h0);
        tick();
        rst = 1'b0;

        // Basic frame from requester 0
        tick();
        ga = 5'd3;
        req_data[63:0] = 64'h0102030405060708;
        push_bytes(88'hAA_03_0102030405060708_27, 11);
        exp_grants.push_back(4'b0001);
        d0  = done_cnt;
        req = 4'b0001;
        wait_grant();
        req = '0;
        wait_idle();
        chk("frame_done_count", 64'(done_cnt - d0), 64'h1);

        // All-ones payload, GA=31: checksum wraps to 0x17
        tick();
        ga = 5'd31;
        req_data[63:0] = 64'hFFFFFFFFFFFFFFFF;
        push_bytes(88'hAA_1F_FFFFFFFFFFFFFFFF_17, 11);
        exp_grants.push_back(4'b0001);
        req = 4'b0001;
        wait_grant();
        req = '0;
        wait_idle();

        // Transmitter stalls for 5 cycles at byte 4
        tick();
        ga = 5'd5;
        req_data[127:64] = 64'h0102030405060708;
        push_bytes(88'hAA_25_0102030405060708_49, 11);
        exp_grants.push_back(4'b0010);
        req = 4'b0010;
        wait_grant();
        req = '0;
        wait_byte(8'h02);
        tick();
        tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_tx_ena", 64'(tx_ena), 64'h1);
            chk("stall_tx_data", 64'(tx_data), 64'h03);
        end
        tick();
        tx_ready = 1'b1;
        wait_idle();

        // GA and payload change after grant: frame uses latched values
        tick();
        ga = 5'd7;
        req_data[191:128] = 64'h1122334455667788;
        push_bytes(88'hAA_47_1122334455667788_AB, 11);
        exp_grants.push_back(4'b0100);
        req = 4'b0100;
        wait_grant();
        req = '0;
        tick();
        ga = 5'd0;
        req_data[191:128] = '0;
        wait_idle();

        // Reset after byte 6 accepted, then a fresh frame from requester 2
        tick();
        ga = 5'd3;
        req_data[63:0]    = 64'h0102030405060708;
        req_data[191:128] = 64'h0102030405060708;
        push_bytes(88'hAA_03_0102030405060708_27, 7);
        exp_grants.push_back(4'b0001);
        d0  = done_cnt;
        req = 4'b0001;
        wait_grant();
        req = '0;
        wait_byte(8'h05);
        tick();
        rst      = 1'b1;
        tx_ready = 1'b0;
        tick();
        rst      = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("abort_tx_ena", 64'(tx_ena), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_grant", 64'(grant), 64'h0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'h0);
        chk("abort_queue_empty", 64'(exp_bytes.size()), 64'h0);
        tick();
        push_bytes(88'hAA_43_0102030405060708_67, 11);
        exp_grants.push_back(4'b0100);
        req = 4'b0100;
        wait_grant();
        req = '0;
        wait_idle();
        chk("fresh_frame_done", 64'(done_cnt - d0), 64'h1);

        // All requests held: rotation 0,1,2,3,0 and 29-clock period
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ga       = 5'd0;
        req_data = {4{64'h0102030405060708}};
        push_bytes(88'hAA_00_0102030405060708_24, 11);
        push_bytes(88'hAA_20_0102030405060708_44, 11);
        push_bytes(88'hAA_40_0102030405060708_64, 11);
        push_bytes(88'hAA_60_0102030405060708_84, 11);
        push_bytes(88'hAA_00_0102030405060708_24, 11);
        exp_grants.push_back(4'b0001);
        exp_grants.push_back(4'b0010);
        exp_grants.push_back(4'b0100);
        exp_grants.push_back(4'b1000);
        exp_grants.push_back(4'b0001);
        gtimes.delete();
        req = 4'b1111;
        repeat (5) wait_grant();
        req = '0;
        wait_idle();
        chk("rotation_grant_count", 64'(gtimes.size()), 64'h5);
        if (gtimes.size() == 5) begin
            for (int i = 1; i < 5; i++) chk("frame_period", 64'(gtimes[i] - gtimes[i-1]), 64'd29);
        end

        tick();
        chk("bytes_left", 64'(exp_bytes.size()), 64'h0);
        chk("grants_left", 64'(exp_grants.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_arb.md
UART_TX_FRAME_ARB -- requirements
Module: uart_tx_frame_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter HEADER, default 8'hAA, meaning frame start byte.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, meaning idle clocks between frames (1..255).
REQ-004 SHALL have port I_clk_10M  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port I_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port I_GA  input  5  geographic address inserted in each frame.
REQ-007 SHALL have port I_req  input  NUM_REQ  per-requester level request; held until granted.
REQ-008 SHALL have port I_req_data  input  64*NUM_REQ  payloads; requester k uses bits [64k+63:64k].
REQ-009 SHALL have port O_grant  output  NUM_REQ  one-hot, one-cycle pulse when the payload is latched.
REQ-010 SHALL have port O_tx_data  output  8  byte to the UART byte transmitter.
REQ-011 SHALL have port O_tx_ena  output  1  byte-valid to the transmitter.
REQ-012 SHALL have port I_tx_ready  input  1  transmitter can accept a byte.
REQ-013 SHALL have port O_busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port O_frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-015 SHALL implement states IDLE, SEND, GAP.
REQ-016 SHALL, in IDLE with any I_req bit high, select a requester round-robin: search starts at (last_granted+1) mod NUM_REQ; last_granted resets to NUM_REQ-1, so requester 0 wins first.
REQ-017 SHALL, in the selection cycle, latch the winner's 64-bit payload, its index and I_GA, pulse O_grant for that index only, clear the byte index to 0 and enter SEND next cycle.
REQ-018 SHALL send 11 bytes per frame in this order: byte0 = HEADER; byte1 = {index[2:0], GA[4:0]}; bytes2..9 = payload MSB byte first; byte10 = checksum.
REQ-019 SHALL compute the checksum as the sum of bytes1..9 modulo 256, accumulated as bytes are accepted; the carry is discarded.
REQ-020 SHALL hold O_tx_ena high and O_tx_data stable through SEND until I_tx_ready is high; a byte is accepted in a cycle with O_tx_ena and I_tx_ready both high.
REQ-021 SHALL advance the byte index by one on each acceptance, so at most one byte is accepted per cycle.
REQ-022 SHALL, on acceptance of byte10, drop O_tx_ena the next cycle, pulse O_frame_done for one cycle, load the gap counter with GAP_CYCLES and enter GAP.
REQ-023 SHALL decrement the gap counter in GAP and enter IDLE in the cycle after it reaches 0, ignoring I_req during GAP.
REQ-024 SHALL keep O_tx_ena low outside SEND; O_tx_data is don't-care when O_tx_ena is low.
REQ-025 SHALL ignore requests that rise or fall during SEND and GAP; only the I_req value sampled in IDLE matters.
REQ-026 SHALL ignore I_req_data and I_GA changes after latching; the frame uses the latched values.
REQ-027 SHALL, when I_req stays high after its grant, re-arbitrate it next IDLE; with all requests high, frames rotate 0,1,..,NUM_REQ-1,0.
REQ-028 SHALL give the minimum frame period as 1 (IDLE) + 11 (SEND, I_tx_ready constantly high) + GAP_CYCLES + 1 clocks.

Reset
REQ-029 SHALL, while I_rst is high at a clock edge, force state IDLE, O_grant=0, O_tx_ena=0, O_tx_data=0, O_busy=0, O_frame_done=0, byte index=0, checksum=0, gap counter=0, last_granted=NUM_REQ-1.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame without sending further bytes and without pulsing O_frame_done; arbitration restarts at requester 0.

Verification
REQ-031 SHALL verify: I_GA=3, I_req=0001, data0=64'h0102030405060708, I_tx_ready=1 -> bytes AA 03 01 02 03 04 05 06 07 08 27, grant 0001, one O_frame_done.
REQ-032 SHALL verify: I_req=1111 held, GAP_CYCLES=16 -> grants in order 0001,0010,0100,1000,0001; byte1 top bits 0,1,2,3,0; frame period 29 clocks.
REQ-033 SHALL verify: I_tx_ready low for 5 cycles at byte 4 -> O_tx_ena stays high, O_tx_data holds 0x03, and no byte is skipped or duplicated.
REQ-034 SHALL verify: data 64'hFFFFFFFFFFFFFFFF, I_GA=31, index 0 -> checksum byte = (0x1F + 8*0xFF) mod 256 = 0x17.
REQ-035 SHALL verify: I_rst pulsed after byte 6 accepted -> next cycle O_tx_ena=0, O_busy=0, no frame_done; next request from requester 2 is sent as a complete fresh frame starting with AA.
REQ-036 SHALL verify: I_GA and data0 changed one cycle after the grant -> the transmitted frame carries the originally latched values.
